// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit.
// Requesters hand in op/a/b; one result is returned with its ID.
module logic_unit_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ID_W-1:0]        resp_id
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    state_e            r_state;
    logic [ID_W-1:0]   r_last_grant;
    logic              r_resp_valid;
    logic [WIDTH-1:0]  r_resp_data;
    logic [ID_W-1:0]   r_resp_id;

    logic              w_found;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ID_W-1:0]   w_scan;
    logic [N_REQ-1:0]  w_gnt_onehot;
    logic              w_accept;
    op_e               w_op;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_result;

    // Find the first valid requester after the last grant, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_scan = ID_W'((int'(r_last_grant) + k) % N_REQ);
            if (!w_found && req_valid[w_scan]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    // Grants are only offered while idle and out of reset.
    always_comb begin
        w_gnt_onehot = '0;
        if (w_found) begin
            w_gnt_onehot = N_REQ'(1) << w_gnt_idx;
        end
    end

    assign w_accept  = rst_n && (r_state == S_IDLE) && w_found;
    assign req_ready = w_accept ? w_gnt_onehot : '0;

    // Route the granted requester's opcode and operands to the unit.
    always_comb begin
        w_op = op_e'(req_op[2*w_gnt_idx +: 2]);
        w_a  = req_a[WIDTH*w_gnt_idx +: WIDTH];
        w_b  = req_b[WIDTH*w_gnt_idx +: WIDTH];
    end

    // Shared bitwise unit; operand B is unused for NOT.
    always_comb begin
        w_result = '0;
        unique case (w_op)
            OP_NOT: w_result = ~w_a;
            OP_AND: w_result = w_a & w_b;
            OP_OR:  w_result = w_a | w_b;
            OP_XOR: w_result = w_a ^ w_b;
            default: w_result = '0;
        endcase
    end

    // Sequencer: capture one result, hold it until the consumer drains it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= LAST_IDX;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_resp_data  <= w_result;
                        r_resp_id    <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (NOT/AND/OR/XOR) among several requesters. Each requester presents an opcode and operands through a valid/ready handshake. The arbiter grants one requester, computes the result in a single shared unit, and returns it with the requester's ID through a valid/ready response channel. It sits between the gate-level datapath primitives and any block that needs occasional bitwise operations without owning dedicated gates.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- ID_W, $clog2(N_REQ), width of resp_id (derived, not overridden)

- clk  input  1  rising-edge clock, single domain
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk
- req_valid  input  N_REQ  bit i: requester i has a request
- req_ready  output  N_REQ  bit i: requester i accepted this cycle (one-hot or zero)
- req_op  input  2*N_REQ  opcode of requester i at bits [2i+1:2i]; 00 NOT, 01 AND, 10 OR, 11 XOR
- req_a  input  N_REQ*WIDTH  operand A of requester i at bits [WIDTH*i +: WIDTH]
- req_b  input  N_REQ*WIDTH  operand B of requester i, same packing; ignored for NOT
- resp_valid  output  1  result held on resp_data/resp_id
- resp_ready  input  1  consumer takes the result this cycle
- resp_data  output  WIDTH  result
- resp_id  output  ID_W  index of the requester that produced resp_data

## Operation
- FSM with two states, IDLE and RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid bit is set, choose the first set bit searching upward from (last_grant+1) mod N_REQ, wrapping.
  - Drive req_ready for only that index. Other bits are 0.
  - The handshake completes in the same cycle because the grant only targets a valid requester.
- On acceptance, at the clock edge:
  - Register resp_data = op(a,b): NOT → ~a; AND → a&b; OR → a|b; XOR → a^b.
  - Register resp_id = granted index and last_grant = granted index.
  - Set resp_valid = 1 and go to RESP.
- RESP:
  - req_ready is all zeros.
  - resp_valid, resp_data and resp_id stay stable until resp_valid && resp_ready.
  - On that edge: resp_valid → 0, state → IDLE.
- No new grant is made in the cycle the response drains. Arbitration resumes in the next IDLE cycle.
- If no req_valid bit is set in IDLE, state, last_grant and all outputs hold.
- Fairness: a requester that holds req_valid continuously is served within N_REQ grants.
- Requesters must hold req_valid, req_op, req_a and req_b stable until accepted. The block does not check this.
- Results are exactly WIDTH bits. There is no carry and no sign handling.

## Timing
- Reset (rst_n low at an edge) forces:
  - state = IDLE, last_grant = N_REQ-1 (requester 0 has highest priority after reset)
  - resp_valid = 0, resp_data = 0, resp_id = 0
  - req_ready = 0 while rst_n is low
- Reset during RESP discards the pending result. There is no partial output.
- req_ready is combinational from req_valid, state and last_grant. It is not combinational from resp_ready.
- Latency: request accepted at edge T → resp_valid = 1 from T to T+1.
- Throughput: at most one transaction every 2 cycles when resp_ready is held high.
- Backpressure: resp_ready low holds the response indefinitely. Pending requesters see req_ready = 0.
- Simultaneous requests: exactly one is accepted per IDLE cycle. Losers keep req_valid and are ordered by the round-robin pointer.
- Wrap-around: after a grant to index N_REQ-1, the search starts at 0.

## Test plan
- Reset then single request: rst_n low 2 cycles, then req_valid=0001, op=00, a=8'hA5 → req_ready=0001 in the first IDLE cycle. Next cycle resp_valid=1, resp_data=8'h5A, resp_id=0. With resp_ready=1, resp_valid drops after 1 cycle.
- Opcode coverage on requester 2: a=8'hF0, b=8'h3C with ops 01/10/11 → resp_data 8'h30 / 8'hFC / 8'hCC, resp_id=2.
- Contention and wrap: all four req_valid held high, resp_ready=1 → grant order 0,1,2,3,0,1. Each requester is granted once per 8 cycles. req_ready is never multi-hot.
- Backpressure: response pending, resp_ready=0 for 5 cycles with req_valid=1111 → resp_valid/resp_data/resp_id stable and req_ready=0000 throughout. After resp_ready=1, the next grant goes to (resp_id+1) mod 4.
- Reset mid-operation: rst_n low while in RESP with resp_data=8'h5A → next cycle resp_valid=0, resp_data=0. The first grant after reset with req_valid=1010 goes to requester 1.
- Idle hold: req_valid=0000 for 10 cycles → req_ready=0, resp_valid=0, and the grant pointer is unchanged (verified by the next grant order).
